// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor, DIGIT bits per clock, LSB digit first
//   clk   in          rising-edge clock
//   rst_n in          asynchronous active-low reset
//   start in          launch request, sampled in IDLE or DONE
//   sub   in          0 = a+b, 1 = a-b, sampled with start
//   a, b  in  WIDTH   operands, sampled with start
//   busy  out         high while in RUN
//   done  out         one-cycle pulse when a result is written
//   sum   out WIDTH   result, held until the next completion
//   cout  out         carry out of the MSB (for sub, 1 = no borrow)
//   ovf   out         signed overflow
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic             carry, a_msb, b_msb;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] res_next;
    logic             last, launch;

    assign slice    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + (DIGIT+1)'(carry);
    // new digit enters at the top; after N shifts the first digit sits at the bottom
    assign res_next = (res >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last     = cnt == CW'(N - 1);
    assign launch   = start && state != RUN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                // subtraction as a + ~b + 1: invert b here, the +1 is the initial carry
                state <= RUN;
                busy  <= 1'b1;
                a_sr  <= a;
                b_sr  <= b ^ {WIDTH{sub}};
                carry <= sub;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1] ^ sub;
                cnt   <= '0;
                res   <= '0;
            end else if (state == RUN) begin
                carry <= slice[DIGIT];
                a_sr  <= a_sr >> DIGIT;
                b_sr  <= b_sr >> DIGIT;
                res   <= res_next;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    sum   <= res_next;
                    cout  <= slice[DIGIT];
                    ovf   <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks of serial_add_sub for DIGIT = 1, 2, 4, 8
module tb_serial_add_sub;
    logic       clk = 1'b0;
    logic       rst_n, start, sub;
    logic [7:0] a, b;
    logic       busy_v [4];
    logic       done_v [4];
    logic       cout_v [4];
    logic       ovf_v  [4];
    logic [7:0] sum_v  [4];
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_add_sub #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .sub   (sub),
            .a     (a),
            .b     (b),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .sum   (sum_v[g]),
            .cout  (cout_v[g]),
            .ovf   (ovf_v[g])
        );
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [DIGIT=%0d] t=%0t: got %0h expected %0h", nm, 1 << i, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int i = 0; i < 4; i++) begin
            chk({nm, " busy"}, i, 32'(busy_v[i]), 0);
            chk({nm, " done"}, i, 32'(done_v[i]), 0);
            chk({nm, " sum"},  i, 32'(sum_v[i]),  0);
            chk({nm, " cout"}, i, 32'(cout_v[i]), 0);
            chk({nm, " ovf"},  i, 32'(ovf_v[i]),  0);
        end
    endtask

    // launch on all instances at once, scramble inputs after the launch edge,
    // then check busy/done timing and the result for each DIGIT
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        a = v.a; b = v.b; sub = v.sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        for (int i = 0; i < 4; i++) chk({nm, " busy0"}, i, 32'(busy_v[i]), 1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk({nm, " done"}, i, 32'(done_v[i]), 32'(k == (8 >> i)));
                chk({nm, " busy"}, i, 32'(busy_v[i]), 32'(k < (8 >> i)));
                if (k == (8 >> i)) begin
                    chk({nm, " sum"},  i, 32'(sum_v[i]),  32'(v.sum));
                    chk({nm, " cout"}, i, 32'(cout_v[i]), 32'(v.cout));
                    chk({nm, " ovf"},  i, 32'(ovf_v[i]),  32'(v.ovf));
                end
            end
        end
    endtask

    initial begin
        vec_t       v;
        logic [8:0] r;
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h9C, 8'h64, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int j = 0; j < 8; j++) run_vec(vecs[j], $sformatf("vec%0d", j));

        // start re-asserted mid-RUN with other operands: DIGIT=1 result unaffected
        @(negedge clk);
        a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) start = 1'b0;
            @(negedge clk);
            if (k == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
            end
            chk("ign done", 0, 32'(done_v[0]), 32'(k == 8));
            chk("ign busy", 0, 32'(busy_v[0]), 32'(k < 8));
            if (k == 8) chk("ign sum", 0, 32'(sum_v[0]), 32'h10);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // reset four cycles into an 8-cycle RUN
        @(negedge clk);
        a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst done", 0, 32'(done_v[0]), 0);
            chk("midrst sum",  0, 32'(sum_v[0]),  0);
        end
        run_vec(vecs[0], "postrst");

        // start held high: DIGIT=4 yields a result every 3 cycles, DIGIT=8 every 2
        @(negedge clk);
        a = 8'h9C; b = 8'h64; sub = 1'b0; start = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("b2b done", 2, 32'(done_v[2]), 32'(k % 3 == 2));
            chk("b2b done", 3, 32'(done_v[3]), 32'(k % 2 == 1));
            if (k % 3 == 2) begin
                chk("b2b sum",  2, 32'(sum_v[2]),  0);
                chk("b2b cout", 2, 32'(cout_v[2]), 1);
            end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        for (int j = 0; j < 200; j++) begin
            v.a   = 8'($urandom);
            v.b   = 8'($urandom);
            v.sub = 1'($urandom);
            r     = {1'b0, v.a} + {1'b0, v.sub ? ~v.b : v.b} + 9'(v.sub);
            v.sum  = r[7:0];
            v.cout = r[8];
            v.ovf  = (v.a[7] == (v.b[7] ^ v.sub)) && (r[7] != v.a[7]);
            run_vec(v, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
